// File: rtl/vga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_pkg : shared display defaults, zoom encodings, scaled-image geometry
// Revision: 1.0
// ----------------------------------------------------------------------------
package vga_pkg;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_V_DISPLAY = 480;

  localparam logic [2:0] ZOOM_Q  = 3'd0;
  localparam logic [2:0] ZOOM_H  = 3'd1;
  localparam logic [2:0] ZOOM_1X = 3'd2;
  localparam logic [2:0] ZOOM_2X = 3'd3;
  localparam logic [2:0] ZOOM_4X = 3'd4;

  typedef struct packed {
    logic [11:0] out_w;
    logic [11:0] out_h;
    logic [11:0] h_off;
    logic [11:0] v_off;
  } geom_t;

  // Scaled size is src*2^zoom/4, centred on the visible area.
  function automatic geom_t zoom_geom(input logic [2:0] zoom, input int h_disp,
                                      input int v_disp, input int src_w, input int src_h);
    geom_t       g;
    logic [15:0] w;
    logic [15:0] h;
    w = (16'(src_w) << zoom) >> 2;
    h = (16'(src_h) << zoom) >> 2;
    g.out_w = w[11:0];
    g.out_h = h[11:0];
    g.h_off = 12'((16'(h_disp) - w) >> 1);
    g.v_off = 12'((16'(v_disp) - h) >> 1);
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pipe_delay.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_pipe_delay : WIDTH x DEPTH shift register, cleared by active-low reset
// Revision: 1.0
// ----------------------------------------------------------------------------
module vga_pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_scaled_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_scaled_addr_gen : raster position -> VdRam address for a centred,
//                       nearest-neighbour scaled image (1/4 .. 4x)
// Revision: 1.0
// ----------------------------------------------------------------------------
module vga_scaled_addr_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int SRC_W     = 160,
  parameter int SRC_H     = 120,
  parameter int ADDR_W    = 17,
  parameter int PIPE_LAT  = 2
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [2:0]        zoom_level,
  input  logic [9:0]        current_x,
  input  logic [9:0]        current_y,
  output logic              is_image_area,
  output logic [ADDR_W-1:0] read_addr,
  output logic [2:0]        zoom_active,
  output logic              frame_tick
);

  geom_t             geom;
  logic [2:0]        zoom_q, zoom_d;
  logic              frame_tick_q, frame_tick_d;
  logic              frame_valid_q, frame_valid_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] col_addr_q, col_addr_d;
  logic [1:0]        sub_x_q, sub_x_d;
  logic [1:0]        sub_y_q, sub_y_d;
  logic [ADDR_W-1:0] cur_col, addr_now;
  logic [1:0]        cur_sub, rep_max, up_s, dn_d;
  logic [11:0]       x_w, y_w, h_end, v_end;
  logic              upscale, boundary, in_area, line_start;
  logic [ADDR_W:0]   pipe_in, pipe_out;

  always_comb begin
    geom       = zoom_geom(zoom_q, H_DISPLAY, V_DISPLAY, SRC_W, SRC_H);
    x_w        = {2'b00, current_x};
    y_w        = {2'b00, current_y};
    h_end      = geom.h_off + geom.out_w;
    v_end      = geom.v_off + geom.out_h;
    boundary   = (current_x == '0) && (y_w == 12'(V_DISPLAY));
    // Image is suppressed until a frame boundary has re-seeded the row counters.
    in_area    = frame_valid_q && (x_w >= geom.h_off) && (x_w < h_end) &&
                 (y_w >= geom.v_off) && (y_w < v_end);
    upscale    = (zoom_q >= ZOOM_1X);
    up_s       = upscale ? 2'(zoom_q - ZOOM_1X) : 2'd0;
    dn_d       = upscale ? 2'd0 : 2'(ZOOM_1X - zoom_q);
    rep_max    = 2'((3'd1 << up_s) - 3'd1);
    line_start = (x_w == geom.h_off);
    cur_col    = line_start ? row_base_q : col_addr_q;
    cur_sub    = line_start ? 2'd0 : sub_x_q;
    addr_now   = in_area ? cur_col : '0;

    zoom_d        = zoom_q;
    frame_tick_d  = boundary;
    frame_valid_d = frame_valid_q;
    row_base_d    = row_base_q;
    col_addr_d    = col_addr_q;
    sub_x_d       = sub_x_q;
    sub_y_d       = sub_y_q;

    if (in_area) begin
      if (upscale) begin
        if (cur_sub == rep_max) begin
          col_addr_d = cur_col + ADDR_W'(1);
          sub_x_d    = 2'd0;
        end else begin
          col_addr_d = cur_col;
          sub_x_d    = cur_sub + 2'd1;
        end
      end else begin
        col_addr_d = cur_col + (ADDR_W'(1) << dn_d);
        sub_x_d    = 2'd0;
      end
      if (x_w == h_end - 12'd1) begin
        if (upscale) begin
          if (sub_y_q == rep_max) begin
            row_base_d = row_base_q + ADDR_W'(SRC_W);
            sub_y_d    = 2'd0;
          end else begin
            sub_y_d    = sub_y_q + 2'd1;
          end
        end else begin
          row_base_d = row_base_q + (ADDR_W'(SRC_W) << dn_d);
        end
      end
    end

    if (boundary) begin
      row_base_d    = '0;
      sub_y_d       = 2'd0;
      frame_valid_d = 1'b1;
      if (zoom_level <= ZOOM_4X) begin
        zoom_d = zoom_level;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset) begin
      zoom_q        <= ZOOM_1X;
      frame_tick_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      row_base_q    <= '0;
      col_addr_q    <= '0;
      sub_x_q       <= 2'd0;
      sub_y_q       <= 2'd0;
    end else begin
      zoom_q        <= zoom_d;
      frame_tick_q  <= frame_tick_d;
      frame_valid_q <= frame_valid_d;
      row_base_q    <= row_base_d;
      col_addr_q    <= col_addr_d;
      sub_x_q       <= sub_x_d;
      sub_y_q       <= sub_y_d;
    end
  end

  assign pipe_in = {in_area, addr_now};

  vga_pipe_delay #(
    .WIDTH (ADDR_W + 1),
    .DEPTH (PIPE_LAT)
  ) u_delay (
    .clk   (pclk),
    .reset (reset),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  assign {is_image_area, read_addr} = pipe_out;
  assign zoom_active = zoom_q;
  assign frame_tick  = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scaled_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vga_scaled_addr_gen : small-geometry instances at latency 1/2/3 plus one
//                          default-geometry instance, against a golden model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_vga_scaled_addr_gen;

  localparam int SH = 64, SV = 48, SW = 16, SHT = 12, SAW = 8, HT = 72, VT = 52;
  localparam int DH = 640, DV = 480, DW = 160, DHT = 120, DAW = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_s, rst_d;
  logic [2:0]            zl_s, zl_d;
  logic [9:0]            x_s, y_s, x_d, y_d;
  logic [3:1]            s_area, s_tick;
  logic [3:1][SAW-1:0]   s_addr;
  logic [3:1][2:0]       s_zoom;
  logic                  d_area, d_tick;
  logic [DAW-1:0]        d_addr;
  logic [2:0]            d_zoom;

  int vec = 0, errs = 0;
  int m_zoom_s = 2, m_zoom_d = 2;
  bit m_valid_s = 0, m_valid_d = 0;
  int hist_area_s[$], hist_addr_s[$], hist_x_s[$], hist_y_s[$];
  int hist_area_d[$], hist_addr_d[$], hist_x_d[$], hist_y_d[$];
  int obs_s[int], obs_d[int];
  int tick_cnt_s = 0, area_cnt_s = 0;

  vga_scaled_addr_gen #(.H_DISPLAY(SH), .V_DISPLAY(SV), .SRC_W(SW), .SRC_H(SHT), .ADDR_W(SAW), .PIPE_LAT(1)) dut1 (
    .pclk(clk), .reset(rst_s), .zoom_level(zl_s), .current_x(x_s), .current_y(y_s),
    .is_image_area(s_area[1]), .read_addr(s_addr[1]), .zoom_active(s_zoom[1]), .frame_tick(s_tick[1]));
  vga_scaled_addr_gen #(.H_DISPLAY(SH), .V_DISPLAY(SV), .SRC_W(SW), .SRC_H(SHT), .ADDR_W(SAW), .PIPE_LAT(2)) dut2 (
    .pclk(clk), .reset(rst_s), .zoom_level(zl_s), .current_x(x_s), .current_y(y_s),
    .is_image_area(s_area[2]), .read_addr(s_addr[2]), .zoom_active(s_zoom[2]), .frame_tick(s_tick[2]));
  vga_scaled_addr_gen #(.H_DISPLAY(SH), .V_DISPLAY(SV), .SRC_W(SW), .SRC_H(SHT), .ADDR_W(SAW), .PIPE_LAT(3)) dut3 (
    .pclk(clk), .reset(rst_s), .zoom_level(zl_s), .current_x(x_s), .current_y(y_s),
    .is_image_area(s_area[3]), .read_addr(s_addr[3]), .zoom_active(s_zoom[3]), .frame_tick(s_tick[3]));
  vga_scaled_addr_gen #(.H_DISPLAY(DH), .V_DISPLAY(DV), .SRC_W(DW), .SRC_H(DHT), .ADDR_W(DAW), .PIPE_LAT(2)) dut_d (
    .pclk(clk), .reset(rst_d), .zoom_level(zl_d), .current_x(x_d), .current_y(y_d),
    .is_image_area(d_area), .read_addr(d_addr), .zoom_active(d_zoom), .frame_tick(d_tick));

  function automatic void golden(input int z, input int x, input int y, input int hd, input int vd,
                                 input int sw, input int sh, output bit area, output int addr);
    int ow, oh, ho, vo, u, v, sx, sy;
    ow = sw * (1 << z) / 4;
    oh = sh * (1 << z) / 4;
    ho = (hd - ow) / 2;
    vo = (vd - oh) / 2;
    area = (x >= ho) && (x < ho + ow) && (y >= vo) && (y < vo + oh);
    addr = 0;
    if (area) begin
      u = x - ho;
      v = y - vo;
      if (z > 2) begin sx = u >> (z - 2); sy = v >> (z - 2); end
      else if (z < 2) begin sx = u << (2 - z); sy = v << (2 - z); end
      else begin sx = u; sy = v; end
      addr = sy * sw + sx;
    end
  endfunction

  // Observation code: addr when in area, -1 outside with addr 0, -2 outside with stray addr, -3 never seen.
  function automatic int obs_code(input bit def, input int x, input int y);
    int key = x * 1024 + y;
    if (def) return obs_d.exists(key) ? obs_d[key] : -3;
    return obs_s.exists(key) ? obs_s[key] : -3;
  endfunction

  task automatic step_s(input int x, input int y);
    bit area; int addr, n, idx, ea, eaddr; bit bnd;
    x_s = 10'(x); y_s = 10'(y);
    bnd = (x == 0) && (y == SV);
    golden(m_zoom_s, x, y, SH, SV, SW, SHT, area, addr);
    if (!m_valid_s || !rst_s) begin area = 0; addr = 0; end
    hist_area_s.push_back(int'(area)); hist_addr_s.push_back(addr);
    hist_x_s.push_back(x); hist_y_s.push_back(y);
    if (!rst_s) begin m_zoom_s = 2; m_valid_s = 0; end
    else if (bnd) begin m_valid_s = 1; if (zl_s <= 3'd4) m_zoom_s = int'(zl_s); end
    @(posedge clk); #1;
    n = hist_area_s.size() - 1;
    if (!rst_s) for (int k = n - 2; k <= n; k++) if (k >= 0) begin hist_area_s[k] = 0; hist_addr_s[k] = 0; end
    for (int l = 1; l <= 3; l++) begin
      idx = n + 1 - l;
      ea = (idx >= 0) ? hist_area_s[idx] : 0;
      eaddr = (idx >= 0) ? hist_addr_s[idx] : 0;
      vec++;
      if (s_area[l] !== 1'(ea) || s_addr[l] !== SAW'(eaddr)) begin
        errs++;
        $display("FAIL pixel L%0d sample %0d: got area=%0b addr=%0d, want area=%0d addr=%0d",
                 l, idx, s_area[l], s_addr[l], ea, eaddr);
      end
      vec++;
      if (s_zoom[l] !== 3'(m_zoom_s) || s_tick[l] !== 1'(rst_s && bnd)) begin
        errs++;
        $display("FAIL zoom/tick L%0d at x=%0d y=%0d: got zoom=%0d tick=%0b, want zoom=%0d tick=%0b",
                 l, x, y, s_zoom[l], s_tick[l], m_zoom_s, rst_s && bnd);
      end
      if (s_area[l] === 1'b1) area_cnt_s++;
      if (l == 2 && idx >= 0)
        obs_s[hist_x_s[idx] * 1024 + hist_y_s[idx]] =
          (s_area[2] === 1'b1) ? int'(s_addr[2]) : ((s_addr[2] === '0) ? -1 : -2);
    end
    if (s_tick[2] === 1'b1) tick_cnt_s++;
  endtask

  task automatic step_d(input int x, input int y);
    bit area; int addr, n, idx, ea, eaddr; bit bnd;
    x_d = 10'(x); y_d = 10'(y);
    bnd = (x == 0) && (y == DV);
    golden(m_zoom_d, x, y, DH, DV, DW, DHT, area, addr);
    if (!m_valid_d || !rst_d) begin area = 0; addr = 0; end
    hist_area_d.push_back(int'(area)); hist_addr_d.push_back(addr);
    hist_x_d.push_back(x); hist_y_d.push_back(y);
    if (!rst_d) begin m_zoom_d = 2; m_valid_d = 0; end
    else if (bnd) begin m_valid_d = 1; if (zl_d <= 3'd4) m_zoom_d = int'(zl_d); end
    @(posedge clk); #1;
    n = hist_area_d.size() - 1;
    if (!rst_d) for (int k = n - 1; k <= n; k++) if (k >= 0) begin hist_area_d[k] = 0; hist_addr_d[k] = 0; end
    idx = n - 1;
    ea = (idx >= 0) ? hist_area_d[idx] : 0;
    eaddr = (idx >= 0) ? hist_addr_d[idx] : 0;
    vec++;
    if (d_area !== 1'(ea) || d_addr !== DAW'(eaddr)) begin
      errs++;
      $display("FAIL default pixel sample %0d: got area=%0b addr=%0d, want area=%0d addr=%0d",
               idx, d_area, d_addr, ea, eaddr);
    end
    vec++;
    if (d_zoom !== 3'(m_zoom_d) || d_tick !== 1'(rst_d && bnd)) begin
      errs++;
      $display("FAIL default zoom/tick at x=%0d y=%0d: got zoom=%0d tick=%0b, want zoom=%0d tick=%0b",
               x, y, d_zoom, d_tick, m_zoom_d, rst_d && bnd);
    end
    if (idx >= 0)
      obs_d[hist_x_d[idx] * 1024 + hist_y_d[idx]] =
        (d_area === 1'b1) ? int'(d_addr) : ((d_addr === '0) ? -1 : -2);
  endtask

  // One small-geometry frame starting at the boundary; optional zoom change and reset pulse.
  task automatic sweep_frame_s(input int chg_y, input int chg_val, input int rst_at, input int rst_len);
    int c = 0;
    int y;
    for (int j = 0; j < VT; j++) begin
      y = (SV + j) % VT;
      for (int x = 0; x < HT; x++) begin
        if (chg_val >= 0 && y == chg_y && x == 0) zl_s = 3'(chg_val);
        if (c == rst_at) rst_s = 1'b0;
        if (rst_at >= 0 && c == rst_at + rst_len) begin rst_s = 1'b1; area_cnt_s = 0; end
        step_s(x, y);
        c++;
      end
    end
  endtask

  task automatic test_reset;
    rst_d = 1'b0; zl_d = 3'd4;
    for (int i = 0; i < 3; i++) step_d(700, 500);
    vec++;
    if (d_area !== 1'b0 || d_addr !== '0 || d_zoom !== 3'd2 || d_tick !== 1'b0) begin
      errs++;
      $display("FAIL reset_default: got area=%0b addr=%0d zoom=%0d tick=%0b, want 0 0 2 0",
               d_area, d_addr, d_zoom, d_tick);
    end
    rst_s = 1'b0; zl_s = 3'd4;
    for (int i = 0; i < 3; i++) step_s(HT - 1, 0);
    for (int l = 1; l <= 3; l++) begin
      vec++;
      if (s_area[l] !== 1'b0 || s_addr[l] !== '0 || s_zoom[l] !== 3'd2 || s_tick[l] !== 1'b0) begin
        errs++;
        $display("FAIL reset_small L%0d: got area=%0b addr=%0d zoom=%0d tick=%0b, want 0 0 2 0",
                 l, s_area[l], s_addr[l], s_zoom[l], s_tick[l]);
      end
    end
  endtask

  task automatic test_default_1x;
    int tx[4] = '{240, 399, 239, 400};
    int ty[4] = '{180, 299, 180, 299};
    int te[4] = '{0, 19199, -1, -1};
    int got;
    rst_d = 1'b1; zl_d = 3'd2;
    step_d(0, DV);
    for (int y = 180; y < 300; y++)
      for (int x = 238; x < 402; x++) step_d(x, y);
    step_d(700, 300); step_d(700, 300);
    for (int i = 0; i < 4; i++) begin
      got = obs_code(1'b1, tx[i], ty[i]);
      vec++;
      if (got !== te[i]) begin
        errs++;
        $display("FAIL default_1x (%0d,%0d): got code %0d, want %0d", tx[i], ty[i], got, te[i]);
      end
    end
  endtask

  task automatic test_default_quarter;
    int tx[3] = '{301, 339, 340};
    int ty[3] = '{226, 254, 254};
    int te[3] = '{644, 18716, -1};
    int got;
    zl_d = 3'd0;
    step_d(0, DV);
    for (int y = 225; y < 255; y++)
      for (int x = 298; x < 342; x++) step_d(x, y);
    step_d(700, 300); step_d(700, 300);
    for (int i = 0; i < 3; i++) begin
      got = obs_code(1'b1, tx[i], ty[i]);
      vec++;
      if (got !== te[i]) begin
        errs++;
        $display("FAIL default_quarter (%0d,%0d): got code %0d, want %0d", tx[i], ty[i], got, te[i]);
      end
    end
    vec++;
    if (d_zoom !== 3'd0) begin
      errs++;
      $display("FAIL default_quarter zoom_active: got %0d, want 0", d_zoom);
    end
    rst_d = 1'b0;
  endtask

  task automatic test_zoom_4x;
    int tx[4] = '{5, 0, 63, 64};
    int ty[4] = '{9, 0, 47, 10};
    int te[4] = '{33, 0, 191, -1};
    int got, t0;
    rst_s = 1'b1; zl_s = 3'd4; t0 = tick_cnt_s;
    sweep_frame_s(-1, -1, -1, 0);
    for (int i = 0; i < 4; i++) begin
      got = obs_code(1'b0, tx[i], ty[i]);
      vec++;
      if (got !== te[i]) begin
        errs++;
        $display("FAIL zoom_4x (%0d,%0d): got code %0d, want %0d", tx[i], ty[i], got, te[i]);
      end
    end
    vec++;
    if (tick_cnt_s - t0 !== 1 || s_zoom[2] !== 3'd4) begin
      errs++;
      $display("FAIL zoom_4x ticks/zoom: got %0d/%0d, want 1/4", tick_cnt_s - t0, s_zoom[2]);
    end
  endtask

  task automatic test_zoom_change;
    int tx[6] = '{24, 39, 23, 15, 16, 19};
    int ty[6] = '{18, 29, 18, 12, 12, 15};
    int te[6] = '{0, 191, -1, -1, 0, 17};
    int got;
    zl_s = 3'd2;
    sweep_frame_s(20, 3, -1, 0);
    vec++;
    if (s_zoom[2] !== 3'd2) begin
      errs++;
      $display("FAIL zoom_change held: got zoom_active=%0d, want 2", s_zoom[2]);
    end
    for (int i = 0; i < 3; i++) begin
      got = obs_code(1'b0, tx[i], ty[i]);
      vec++;
      if (got !== te[i]) begin
        errs++;
        $display("FAIL zoom_change 1x (%0d,%0d): got code %0d, want %0d", tx[i], ty[i], got, te[i]);
      end
    end
    sweep_frame_s(-1, -1, -1, 0);
    vec++;
    if (s_zoom[2] !== 3'd3) begin
      errs++;
      $display("FAIL zoom_change applied: got zoom_active=%0d, want 3", s_zoom[2]);
    end
    for (int i = 3; i < 6; i++) begin
      got = obs_code(1'b0, tx[i], ty[i]);
      vec++;
      if (got !== te[i]) begin
        errs++;
        $display("FAIL zoom_change 2x (%0d,%0d): got code %0d, want %0d", tx[i], ty[i], got, te[i]);
      end
    end
  endtask

  task automatic test_invalid_zoom;
    int got, t0;
    zl_s = 3'd6; t0 = tick_cnt_s;
    sweep_frame_s(-1, -1, -1, 0);
    got = obs_code(1'b0, 19, 15);
    vec++;
    if (s_zoom[2] !== 3'd3 || tick_cnt_s - t0 !== 1 || got !== 17) begin
      errs++;
      $display("FAIL invalid_zoom: got zoom=%0d ticks=%0d code=%0d, want 3 1 17",
               s_zoom[2], tick_cnt_s - t0, got);
    end
  endtask

  task automatic test_reset_midframe;
    int rst_at, rst_len;
    zl_s = 3'd4;
    sweep_frame_s(-1, -1, -1, 0);
    rst_at  = (VT - SV) * HT + 8 * HT + $urandom_range(0, 20 * HT);
    rst_len = $urandom_range(1, 3);
    sweep_frame_s(-1, -1, rst_at, rst_len);
    for (int l = 1; l <= 3; l++) begin
      vec++;
      if (s_zoom[l] !== 3'd2) begin
        errs++;
        $display("FAIL reset_midframe L%0d zoom_active: got %0d, want 2", l, s_zoom[l]);
      end
    end
    vec++;
    if (area_cnt_s !== 0) begin
      errs++;
      $display("FAIL reset_midframe early image: got %0d in-area outputs, want 0", area_cnt_s);
    end
    for (int f = 0; f < 3; f++) begin
      zl_s = 3'($urandom_range(0, 7));
      sweep_frame_s($urandom_range(0, VT - 1), $urandom_range(0, 7), -1, 0);
    end
  endtask

  initial begin
    rst_s = 1'b0; rst_d = 1'b0;
    zl_s = 3'd2; zl_d = 3'd2;
    x_s = '0; y_s = '0; x_d = '0; y_d = '0;
    test_reset;
    test_default_1x;
    test_default_quarter;
    test_zoom_4x;
    test_zoom_change;
    test_invalid_zoom;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire
